delta_t_power_gen: RTL

Time-parameter generator that sits directly upstream of the covariance-prediction CMU blocks (the P(1,1) unit and its siblings). It takes one IEEE-754 double time step `dt` and produces `delta_t1`..`delta_t6`, the power-series time coefficients those units consume. It uses two shared `fp_multiplier` instances under a sequential FSM, keeping FP IP usage low. All six outputs update together.

---
 rtl/delta_t_power_gen.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/delta_t_power_gen.sv
// delta_t_power_gen: dt -> delta_t1..delta_t6 on two shared fp_multipliers; valid_out R*(L+1)+1 cycles after start.
// No backpressure, start while busy is dropped; DELTA_T_TAYLOR_SCALE_EN adds three 1/k! scaling rounds (R=6, else R=3).
module fp_multiplier #(
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic        finish,
    output logic [63:0] result
);
    logic [63:0]        a_q, b_q;
    logic [LATENCY-1:0] pipe_q;
    logic [105:0]       prod;
    logic [52:0]        mant;
    logic [53:0]        mant_r;
    logic               guard, sticky;
    logic signed [12:0] exp_s, exp_f;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            pipe_q <= '0;
        end else begin
            if (valid) begin
                a_q <= a;
                b_q <= b;
            end
            pipe_q[0] <= valid;
            for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign finish = pipe_q[LATENCY-1];

    // Round-to-nearest-even; a zero exponent on either operand flushes to signed zero.
    always_comb begin
        prod = 106'({1'b1, a_q[51:0]}) * 106'({1'b1, b_q[51:0]});
        if (prod[105]) begin
            mant   = prod[105:53];
            guard  = prod[52];
            sticky = |prod[51:0];
        end else begin
            mant   = prod[104:52];
            guard  = prod[51];
            sticky = |prod[50:0];
        end
        mant_r = {1'b0, mant} + {53'd0, guard & (sticky | mant[0])};
        exp_s  = $signed({2'b00, a_q[62:52]}) + $signed({2'b00, b_q[62:52]})
                 - 13'sd1023 + $signed({12'd0, prod[105]});
        exp_f  = exp_s + $signed({12'd0, mant_r[53]});
        result = {a_q[63] ^ b_q[63], 63'd0};
        if (a_q[62:52] != 11'd0 && b_q[62:52] != 11'd0) begin
            if (exp_f >= 13'sd2047)
                result[62:52] = 11'h7FF;
            else if (exp_f > 13'sd0)
                result[62:0] = {exp_f[10:0], mant_r[53] ? mant_r[52:1] : mant_r[51:0]};
        end
    end
endmodule

module delta_t_power_gen #(
    parameter int DBL_WIDTH   = 64,
    parameter int MUL_LATENCY = 2,
    parameter int MUL1_SKEW   = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [DBL_WIDTH-1:0] dt,
    output logic [DBL_WIDTH-1:0] delta_t1,
    output logic [DBL_WIDTH-1:0] delta_t2,
    output logic [DBL_WIDTH-1:0] delta_t3,
    output logic [DBL_WIDTH-1:0] delta_t4,
    output logic [DBL_WIDTH-1:0] delta_t5,
    output logic [DBL_WIDTH-1:0] delta_t6,
    output logic                 busy,
    output logic                 valid_out
);
`ifdef DELTA_T_TAYLOR_SCALE_EN
    typedef enum logic [2:0] {S_IDLE, S_R1, S_R2, S_R3, S_K23, S_K45, S_K6} state_t;
    localparam logic [63:0] C2 = 64'h3FE0000000000000;
    localparam logic [63:0] C3 = 64'h3FC5555555555555;
    localparam logic [63:0] C4 = 64'h3FA5555555555555;
    localparam logic [63:0] C5 = 64'h3F81111111111111;
    localparam logic [63:0] C6 = 64'h3F56C16C16C16C17;
`else
    typedef enum logic [1:0] {S_IDLE, S_R1, S_R2, S_R3} state_t;
`endif

    state_t                 state_q, state_d;
    logic [DBL_WIDTH-1:0]   p1_q, p2_q, p3_q, p4_q, p5_q, p6_q;
    logic [DBL_WIDTH-1:0]   p1_d, p2_d, p3_d, p4_d, p5_d, p6_d;
    logic [DBL_WIDTH-1:0]   a0_q, b0_q, a1_q, b1_q, a0_d, b0_d, a1_d, b1_d;
    logic [DBL_WIDTH-1:0]   t1_q, t2_q, t3_q, t4_q, t5_q, t6_q;
    logic                   vld0_q, vld1_q, vld0_d, vld1_d;
    logic                   flag0_q, flag1_q, flag0_d, flag1_d;
    logic                   valid_out_q;
    logic                   fin0, fin1, two_mul, in_round, cap0, cap1, round_done, run_done;
    logic [DBL_WIDTH-1:0]   res0, res1;

    fp_multiplier #(.LATENCY(MUL_LATENCY)) u_mul0 (
        .clk(clk), .rst_n(rst_n), .valid(vld0_q), .a(a0_q), .b(b0_q), .finish(fin0), .result(res0));
    fp_multiplier #(.LATENCY(MUL_LATENCY + MUL1_SKEW)) u_mul1 (
        .clk(clk), .rst_n(rst_n), .valid(vld1_q), .a(a1_q), .b(b1_q), .finish(fin1), .result(res1));

    always_comb begin
        two_mul    = (state_q == S_R2) || (state_q == S_R3)
`ifdef DELTA_T_TAYLOR_SCALE_EN
                     || (state_q == S_K23) || (state_q == S_K45)
`endif
                     ;
        in_round   = (state_q != S_IDLE);
        cap0       = in_round & fin0 & ~flag0_q;
        cap1       = two_mul & fin1 & ~flag1_q;
        // Same-edge finishes count, so an unskewed round closes on its finish edge.
        round_done = in_round & (flag0_q | fin0) & (~two_mul | flag1_q | fin1);
        state_d = state_q;
        p1_d = p1_q; p2_d = p2_q; p3_d = p3_q; p4_d = p4_q; p5_d = p5_q; p6_d = p6_q;
        a0_d = a0_q; b0_d = b0_q; a1_d = a1_q; b1_d = b1_q;
        vld0_d   = 1'b0;
        vld1_d   = 1'b0;
        flag0_d  = flag0_q | cap0;
        flag1_d  = flag1_q | cap1;
        run_done = 1'b0;

        case (state_q)
            S_R1:    if (cap0) p2_d = res0;
            S_R2:    begin if (cap0) p3_d = res0; if (cap1) p4_d = res1; end
            S_R3:    begin if (cap0) p5_d = res0; if (cap1) p6_d = res1; end
`ifdef DELTA_T_TAYLOR_SCALE_EN
            S_K23:   begin if (cap0) p2_d = res0; if (cap1) p3_d = res1; end
            S_K45:   begin if (cap0) p4_d = res0; if (cap1) p5_d = res1; end
            S_K6:    if (cap0) p6_d = res0;
`endif
            default: ;
        endcase

        if (state_q == S_IDLE) begin
            if (start && !valid_out_q) begin
                state_d = S_R1;
                p1_d = dt; a0_d = dt; b0_d = dt;
                vld0_d = 1'b1;
            end
        end else if (round_done) begin
            flag0_d = 1'b0;
            flag1_d = 1'b0;
            case (state_q)
                S_R1: begin
                    state_d = S_R2; vld0_d = 1'b1; vld1_d = 1'b1;
                    a0_d = p2_d; b0_d = p1_q; a1_d = p2_d; b1_d = p2_d;
                end
                S_R2: begin
                    state_d = S_R3; vld0_d = 1'b1; vld1_d = 1'b1;
                    a0_d = p4_d; b0_d = p1_q; a1_d = p3_d; b1_d = p3_d;
                end
`ifdef DELTA_T_TAYLOR_SCALE_EN
                S_R3: begin
                    state_d = S_K23; vld0_d = 1'b1; vld1_d = 1'b1;
                    a0_d = p2_d; b0_d = C2; a1_d = p3_d; b1_d = C3;
                end
                S_K23: begin
                    state_d = S_K45; vld0_d = 1'b1; vld1_d = 1'b1;
                    a0_d = p4_d; b0_d = C4; a1_d = p5_d; b1_d = C5;
                end
                S_K45: begin
                    state_d = S_K6; vld0_d = 1'b1;
                    a0_d = p6_d; b0_d = C6;
                end
`endif
                default: begin
                    state_d  = S_IDLE;
                    run_done = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            p1_q <= '0; p2_q <= '0; p3_q <= '0; p4_q <= '0; p5_q <= '0; p6_q <= '0;
            a0_q <= '0; b0_q <= '0; a1_q <= '0; b1_q <= '0;
            t1_q <= '0; t2_q <= '0; t3_q <= '0; t4_q <= '0; t5_q <= '0; t6_q <= '0;
            vld0_q <= 1'b0; vld1_q <= 1'b0;
            flag0_q <= 1'b0; flag1_q <= 1'b0;
            valid_out_q <= 1'b0;
        end else begin
            state_q <= state_d;
            p1_q <= p1_d; p2_q <= p2_d; p3_q <= p3_d; p4_q <= p4_d; p5_q <= p5_d; p6_q <= p6_d;
            a0_q <= a0_d; b0_q <= b0_d; a1_q <= a1_d; b1_q <= b1_d;
            vld0_q <= vld0_d; vld1_q <= vld1_d;
            flag0_q <= flag0_d; flag1_q <= flag1_d;
            valid_out_q <= run_done;
            if (run_done) begin
                t1_q <= p1_q; t2_q <= p2_d; t3_q <= p3_d;
                t4_q <= p4_d; t5_q <= p5_d; t6_q <= p6_d;
            end
        end
    end

    assign delta_t1  = t1_q;
    assign delta_t2  = t2_q;
    assign delta_t3  = t3_q;
    assign delta_t4  = t4_q;
    assign delta_t5  = t5_q;
    assign delta_t6  = t6_q;
    assign valid_out = valid_out_q;
    assign busy      = (state_q != S_IDLE) | valid_out_q;
endmodule
